// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: state encoding,
// address width and the default reset PC.
package pipe_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ENTER = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: PC hold, IF/ID and ID/EX flush, fetch
// redirect, and interrupt entry sequencing (drain EX, capture return
// PC, redirect to the vector for one ENTER cycle).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              jump_req_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              div_busy_i,
  input  logic              bus_wait_i,
  input  logic [ADDR_W-1:0] id_pc_i,
  input  logic              irq_req_i,
  input  logic [ADDR_W-1:0] irq_vec_i,
  output logic              hold_pc_o,
  output logic              flush_if_id_o,
  output logic              flush_id_ex_o,
  output logic              redirect_o,
  output logic [ADDR_W-1:0] redirect_addr_o,
  output logic              irq_ack_o,
  output logic [ADDR_W-1:0] irq_epc_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] vec_q, vec_d;
  logic [ADDR_W-1:0] epc_q, epc_d;

  logic              freeze;
  logic              hold_c, flush_c, redir_c, ack_c;
  logic [ADDR_W-1:0] redir_addr_c;

  assign freeze = bus_wait_i | div_busy_i;

  // State, vector and return-PC registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_RUN;
      vec_q   <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      epc_q   <= epc_d;
    end
  end

  // Next-state logic and raw control decisions from state and inputs.
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    epc_d        = epc_q;
    hold_c       = 1'b0;
    flush_c      = 1'b0;
    redir_c      = 1'b0;
    redir_addr_c = jump_addr_i;
    ack_c        = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (freeze) begin
          hold_c  = 1'b1;
          flush_c = 1'b1;
        end else if (jump_req_i) begin
          redir_c = 1'b1;
          flush_c = 1'b1;
        end
        if (irq_req_i) begin
          vec_d = irq_vec_i;
          if (freeze) begin
            state_d = ST_DRAIN;
          end else if (jump_req_i) begin
            // The jump target is where execution resumes after the handler.
            epc_d   = jump_addr_i;
            state_d = ST_ENTER;
          end else begin
            // Freeze so the ID instruction stays put; it is the return PC.
            hold_c  = 1'b1;
            flush_c = 1'b1;
            epc_d   = id_pc_i;
            state_d = ST_ENTER;
          end
        end
      end

      ST_DRAIN: begin
        if (freeze) begin
          hold_c  = 1'b1;
          flush_c = 1'b1;
        end else if (jump_req_i) begin
          redir_c = 1'b1;
          flush_c = 1'b1;
          epc_d   = jump_addr_i;
          state_d = ST_ENTER;
        end else begin
          hold_c  = 1'b1;
          flush_c = 1'b1;
          epc_d   = id_pc_i;
          state_d = ST_ENTER;
        end
      end

      ST_ENTER: begin
        redir_c      = 1'b1;
        redir_addr_c = vec_q;
        flush_c      = 1'b1;
        ack_c        = 1'b1;
        state_d      = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Output stage: reset forces everything quiet in the same cycle.
  always_comb begin
    hold_pc_o       = 1'b0;
    flush_if_id_o   = 1'b0;
    flush_id_ex_o   = 1'b0;
    redirect_o      = 1'b0;
    redirect_addr_o = RESET_PC;
    irq_ack_o       = 1'b0;
    irq_epc_o       = '0;
    if (rstn) begin
      hold_pc_o     = hold_c;
      flush_if_id_o = flush_c;
      flush_id_ex_o = flush_c;
      redirect_o    = redir_c;
      if (redir_c) begin
        redirect_addr_o = redir_addr_c;
      end
      irq_ack_o = ack_c;
      irq_epc_o = epc_q;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the stimulus process pushes the
// hand-computed expected outputs for each cycle, the monitor pops and
// compares them on the falling edge.
module tb_pipe_ctrl;

  localparam logic [31:0] RP = 32'h0000_1000;

  typedef struct packed {
    logic        hold;
    logic        fif;
    logic        fie;
    logic        red;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] epc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        jump_req_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        div_busy_i = 1'b0;
  logic        bus_wait_i = 1'b0;
  logic [31:0] id_pc_i = '0;
  logic        irq_req_i = 1'b0;
  logic [31:0] irq_vec_i = '0;
  logic        hold_pc_o, flush_if_id_o, flush_id_ex_o, redirect_o, irq_ack_o;
  logic [31:0] redirect_addr_o, irq_epc_o;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   txn = 0;

  pipe_ctrl #(.RESET_PC(RP)) dut (
    .clk(clk), .rstn(rstn),
    .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i),
    .div_busy_i(div_busy_i), .bus_wait_i(bus_wait_i),
    .id_pc_i(id_pc_i), .irq_req_i(irq_req_i), .irq_vec_i(irq_vec_i),
    .hold_pc_o(hold_pc_o), .flush_if_id_o(flush_if_id_o),
    .flush_id_ex_o(flush_id_ex_o), .redirect_o(redirect_o),
    .redirect_addr_o(redirect_addr_o), .irq_ack_o(irq_ack_o),
    .irq_epc_o(irq_epc_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t ex(logic h, logic f, logic r, logic [31:0] a,
                              logic ack, logic [31:0] epc);
    exp_t e;
    e.hold = h;
    e.fif  = f;
    e.fie  = f;
    e.red  = r;
    e.addr = r ? a : RP;
    e.ack  = ack;
    e.epc  = epc;
    return e;
  endfunction

  // One cycle of stimulus: apply inputs just after the edge, queue expectation.
  task automatic drive(input logic r, input logic bw, input logic db,
                       input logic jr, input logic [31:0] ja,
                       input logic [31:0] pc, input logic irq,
                       input logic [31:0] vec, input exp_t e);
    @(posedge clk);
    #1;
    rstn        = r;
    bus_wait_i  = bw;
    div_busy_i  = db;
    jump_req_i  = jr;
    jump_addr_i = ja;
    id_pc_i     = pc;
    irq_req_i   = irq;
    irq_vec_i   = vec;
    exp_q.push_back(e);
  endtask

  // Monitor: the outputs are combinational, compare mid-cycle.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{hold_pc_o, flush_if_id_o, flush_id_ex_o, redirect_o,
              redirect_addr_o, irq_ack_o, irq_epc_o};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL txn%0d outputs: got h=%b fi=%b fe=%b r=%b a=%h ack=%b epc=%h want h=%b fi=%b fe=%b r=%b a=%h ack=%b epc=%h",
                   txn, a.hold, a.fif, a.fie, a.red, a.addr, a.ack, a.epc,
                   e.hold, e.fif, e.fie, e.red, e.addr, e.ack, e.epc);
        end else begin
          $display("ok   txn%0d h=%b fi=%b fe=%b r=%b a=%h ack=%b epc=%h",
                   txn, a.hold, a.fif, a.fie, a.red, a.addr, a.ack, a.epc);
        end
        txn++;
      end
    end
  end

  initial begin
    int guard;
    // rst bw db jr ja pc irq vec expected
    // Reset state.
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, ex(0, 0, 0, 0, 0, 0));
    // Idle.
    drive(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, ex(0, 0, 0, 0, 0, 0));
    // Plain jump.
    drive(1, 0, 0, 1, 32'h100, 32'h0, 0, 32'h0, ex(0, 1, 1, 32'h100, 0, 0));
    // Divider busy overrides jump for 3 cycles, then jump goes through.
    drive(1, 0, 1, 1, 32'h104, 32'h0, 0, 32'h0, ex(1, 1, 0, 0, 0, 0));
    drive(1, 0, 1, 1, 32'h104, 32'h0, 0, 32'h0, ex(1, 1, 0, 0, 0, 0));
    drive(1, 0, 1, 1, 32'h104, 32'h0, 0, 32'h0, ex(1, 1, 0, 0, 0, 0));
    drive(1, 0, 0, 1, 32'h104, 32'h0, 0, 32'h0, ex(0, 1, 1, 32'h104, 0, 0));
    // Irq without stall: freeze, then ENTER (inputs ignored there).
    drive(1, 0, 0, 0, 32'h0, 32'h44, 1, 32'h80, ex(1, 1, 0, 0, 0, 0));
    drive(1, 1, 0, 1, 32'h300, 32'h48, 1, 32'hEE, ex(0, 1, 1, 32'h80, 1, 32'h44));
    drive(1, 0, 0, 0, 32'h0, 32'h48, 0, 32'h0, ex(0, 0, 0, 0, 0, 32'h44));
    // Irq during a 4-cycle bus stall; jumps ignored while frozen.
    drive(1, 1, 0, 0, 32'h0, 32'h50, 1, 32'h90, ex(1, 1, 0, 0, 0, 32'h44));
    drive(1, 1, 0, 1, 32'h400, 32'h50, 1, 32'h94, ex(1, 1, 0, 0, 0, 32'h44));
    drive(1, 1, 0, 1, 32'h400, 32'h50, 1, 32'h94, ex(1, 1, 0, 0, 0, 32'h44));
    drive(1, 1, 0, 1, 32'h400, 32'h50, 1, 32'h94, ex(1, 1, 0, 0, 0, 32'h44));
    drive(1, 0, 0, 0, 32'h0, 32'h58, 1, 32'h94, ex(1, 1, 0, 0, 0, 32'h44));
    drive(1, 0, 0, 0, 32'h0, 32'h5C, 1, 32'h94, ex(0, 1, 1, 32'h90, 1, 32'h58));
    drive(1, 0, 0, 0, 32'h0, 32'h5C, 0, 32'h0, ex(0, 0, 0, 0, 0, 32'h58));
    // Irq together with jump.
    drive(1, 0, 0, 1, 32'h200, 32'h60, 1, 32'hA0, ex(0, 1, 1, 32'h200, 0, 32'h58));
    drive(1, 0, 0, 0, 32'h0, 32'h64, 1, 32'hA4, ex(0, 1, 1, 32'hA0, 1, 32'h200));
    drive(1, 0, 0, 0, 32'h0, 32'h64, 0, 32'h0, ex(0, 0, 0, 0, 0, 32'h200));
    // DRAIN exits on a jump.
    drive(1, 0, 1, 0, 32'h0, 32'h68, 1, 32'hB0, ex(1, 1, 0, 0, 0, 32'h200));
    drive(1, 0, 0, 1, 32'h500, 32'h6C, 1, 32'hB4, ex(0, 1, 1, 32'h500, 0, 32'h200));
    drive(1, 0, 0, 0, 32'h0, 32'h6C, 1, 32'hB4, ex(0, 1, 1, 32'hB0, 1, 32'h500));
    drive(1, 0, 0, 0, 32'h0, 32'h6C, 0, 32'h0, ex(0, 0, 0, 0, 0, 32'h500));
    // Reset while in DRAIN.
    drive(1, 1, 0, 0, 32'h0, 32'h70, 1, 32'hC0, ex(1, 1, 0, 0, 0, 32'h500));
    drive(1, 1, 0, 1, 32'h600, 32'h70, 1, 32'hC0, ex(1, 1, 0, 0, 0, 32'h500));
    drive(0, 1, 0, 1, 32'h600, 32'h70, 1, 32'hC0, ex(0, 0, 0, 0, 0, 0));
    drive(1, 0, 0, 0, 32'h0, 32'h70, 0, 32'h0, ex(0, 0, 0, 0, 0, 0));
    // After reset the controller is back in RUN and accepts a fresh irq.
    drive(1, 0, 0, 0, 32'h0, 32'h74, 1, 32'hD0, ex(1, 1, 0, 0, 0, 0));
    drive(1, 0, 0, 0, 32'h0, 32'h78, 1, 32'hD4, ex(0, 1, 1, 32'hD0, 1, 32'h74));
    drive(1, 0, 0, 0, 32'h0, 32'h78, 0, 32'h0, ex(0, 0, 0, 0, 0, 32'h74));

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
